crc9_parallel_engine: RTL and testbench
=======================================

Name: crc9_parallel_engine

Overview:
- Single-cycle parallel CRC generator for 16-bit data words.
- Polynomial is x^9 + x^8 + x^5 + x^4 + x + 1.
- Result is registered, with a 1-cycle latency, a valid strobe, and a compare-against-reference flag for checker use.
- Sits on a word stream (e.g. header protection) where a new word may arrive every cycle.

Parameters:
- DATA_W, 16, data word width in bits; fixed at 16 for this polynomial configuration.
- CRC_W, 9, CRC width in bits.
- POLY, 9'h133, polynomial coefficients x^8..x^0 (x^9 implicit). Full divisor is 10'h333.
- INIT, 9'h000, register seed before division.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_valid  in  1  qualifies data_in and crc_ref this cycle.
- data_in  in  16  message word; bit 15 is the first bit shifted (MSB first).
- crc_ref  in  9  expected CRC for data_in; used only for crc_match.
- crc_out  out  9  registered CRC of the last accepted word.
- crc_valid  out  1  high for one cycle per accepted word.
- crc_match  out  1  registered (computed CRC == crc_ref); meaningful only while crc_valid=1.

Behaviour:
- CRC definition: remainder of (data_in * x^9) mod G(x), with G = 10'h333.
  - Shifting is MSB first, seeded with INIT=0.
  - No input or output reflection; no final XOR.
- Per-word, not cumulative: each accepted word starts from INIT, with no chaining across words.
- The CRC function is pure combinational XOR logic. The implementation may be an unrolled 16-step shift/XOR loop or an equivalent XOR matrix.
- Equivalent bit contributions (XOR together the entries for each set data bit):
  - b0=0x133, b1=0x155, b2=0x199, b3=0x001
  - b4=0x002, b5=0x004, b6=0x008, b7=0x010
  - b8=0x020, b9=0x040, b10=0x080, b11=0x100
  - b12=0x133, b13=0x155, b14=0x199, b15=0x001
- Rising edge with rst=1: crc_out<=0, crc_valid<=0, crc_match<=0. Reset has priority over data_valid.
- Rising edge with rst=0 and data_valid=1:
  - crc_out <= CRC(data_in)
  - crc_match <= (CRC(data_in)==crc_ref)
  - crc_valid <= 1
- Rising edge with rst=0 and data_valid=0: crc_valid<=0; crc_out and crc_match hold their previous values.
- Latency: exactly 1 clock from the accepting edge to the output.
- Throughput: one word per clock; back-to-back valid words each produce their own result on consecutive cycles.
- Reset asserted mid-stream: a word presented in the same cycle as rst is discarded. The first valid word after rst deasserts is processed normally.
- No X propagation: outputs are defined after the first reset. Before the first reset, outputs are don't-care.
- No handshake back-pressure; the block always accepts.

Test Plan:
- Reset check: rst=1 for 2 cycles with data_valid=1, data_in=16'hFFFF -> crc_out=0x000, crc_valid=0, crc_match=0.
- Single words, one idle cycle between each, each with crc_ref set to the expected value -> one cycle later crc_valid=1 and crc_match=1:
  - 0x0000 -> 0x000
  - 0x0001 -> 0x133
  - 0x0002 -> 0x155
  - 0x0003 -> 0x066
  - 0x8000 -> 0x001
  - 0x1234 -> 0x0EC
  - 0xFFFF -> 0x1FE
- Back-to-back: 0x0001, 0x0002, 0xFFFF on 3 consecutive cycles -> outputs 0x133, 0x155, 0x1FE on the 3 following cycles; crc_valid high all 3 cycles, then low.
- Mismatch: data_in=0x1234, crc_ref=0x0ED -> crc_out=0x0EC, crc_match=0.
- Hold and idle: after the 0xFFFF result, drop data_valid for 3 cycles -> crc_valid=0, crc_out stays 0x1FE.
- Mid-stream reset: valid 0x0001, then rst=1 with valid 0x0002 in the same cycle -> crc_out=0x000 and crc_valid=0 after that edge. Next valid 0x0003 -> 0x066.
- Random: 200 random 16-bit words compared against a software model of the same polynomial -> all match.

Source files
------------

// File: rtl/crc9_parallel_engine.sv
// Single-cycle parallel CRC-9 (G = 0x333) over one 16-bit word, registered with
// a valid strobe and a compare-against-reference flag. Each word starts from INIT.
module crc9_parallel_engine #(
  parameter int              DATA_W = 16,
  parameter int              CRC_W  = 9,
  parameter logic [CRC_W-1:0] POLY  = 9'h133,
  parameter logic [CRC_W-1:0] INIT  = 9'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_ref,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_match
);

  localparam int STAGES = 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CRC_W-1:0]  ref_crc;
  } req_t;

  typedef struct packed {
    logic [CRC_W-1:0] crc;
    logic             match;
  } rsp_t;

  // Unrolled MSB-first shift/XOR; synthesis flattens this into an XOR matrix.
  function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = INIT;
    for (int i = DATA_W-1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  req_t              req;
  rsp_t              rsp_d, rsp_q;
  logic [STAGES:1]   vld_pipe;

  always_comb begin
    req.data    = data_in;
    req.ref_crc = crc_ref;
    rsp_d.crc   = crc_calc(req.data);
    rsp_d.match = (rsp_d.crc == req.ref_crc);
  end

  // Reset wins over a word presented in the same cycle; idle cycles hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q       <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= data_valid;
      if (data_valid) rsp_q <= rsp_d;
    end
  end

  assign crc_out   = rsp_q.crc;
  assign crc_match = rsp_q.match;
  assign crc_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_crc9_parallel_engine.sv
// Bench for crc9_parallel_engine: polynomial long-division model checked every
// cycle, plus directed literal expectations from hand-computed CRCs.
module tb_crc9_parallel_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data_in;
  logic [8:0]  crc_ref;
  logic [8:0]  crc_out;
  logic        crc_valid;
  logic        crc_match;

  int n_cmp = 0;
  int n_bad = 0;

  crc9_parallel_engine dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .crc_ref    (crc_ref),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid),
    .crc_match  (crc_match)
  );

  always #5 clk = ~clk;

  // Remainder of (d * x^9) mod 0x333 by plain long division on a 25-bit value.
  function automatic logic [8:0] model_crc(input logic [15:0] d);
    logic [24:0] v;
    logic [24:0] g;
    v = {d, 9'h000};
    for (int b = 24; b >= 9; b--) begin
      g = 25'h333 << (b - 9);
      if (v[b]) v = v ^ g;
    end
    return v[8:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: registered result updated on accepted words.
  logic       live = 1'b0;
  logic [8:0] exp_out;
  logic       exp_valid, exp_match;

  always @(posedge clk) begin
    if (rst) begin
      live      <= 1'b1;
      exp_out   <= 9'h000;
      exp_valid <= 1'b0;
      exp_match <= 1'b0;
    end else begin
      exp_valid <= data_valid;
      if (data_valid) begin
        exp_out   <= model_crc(data_in);
        exp_match <= (model_crc(data_in) == crc_ref);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_valid", {15'b0, crc_valid}, {15'b0, exp_valid});
      check("model_out",   {7'b0, crc_out},    {7'b0, exp_out});
      check("model_match", {15'b0, crc_match}, {15'b0, exp_match});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [15:0] d; logic [8:0] c; } vec_t;
  vec_t vecs [7] = '{
    '{16'h0000, 9'h000}, '{16'h0001, 9'h133}, '{16'h0002, 9'h155},
    '{16'h0003, 9'h066}, '{16'h8000, 9'h001}, '{16'h1234, 9'h0EC},
    '{16'hFFFF, 9'h1FE}
  };

  initial begin
    // pin the model against hand-computed values
    for (int i = 0; i < 7; i++)
      check("model_pin", {7'b0, model_crc(vecs[i].d)}, {7'b0, vecs[i].c});

    rst = 1'b1; data_valid = 1'b1; data_in = 16'hFFFF; crc_ref = 9'h000;
    step(); step();
    check("rst_out",   {7'b0, crc_out}, 16'h000);
    check("rst_valid", {15'b0, crc_valid}, 16'h0);
    check("rst_match", {15'b0, crc_match}, 16'h0);
    rst = 1'b0; data_valid = 1'b0;
    step();

    // single words with an idle cycle between
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1; data_in = vecs[i].d; crc_ref = vecs[i].c;
      step();
      check("single_out",   {7'b0, crc_out}, {7'b0, vecs[i].c});
      check("single_valid", {15'b0, crc_valid}, 16'h1);
      check("single_match", {15'b0, crc_match}, 16'h1);
      data_valid = 1'b0;
      step();
      check("single_drop", {15'b0, crc_valid}, 16'h0);
    end

    // back-to-back
    data_valid = 1'b1;
    data_in = 16'h0001; crc_ref = 9'h133; step();
    check("b2b_0", {7'b0, crc_out}, 16'h133);
    data_in = 16'h0002; crc_ref = 9'h155; step();
    check("b2b_1", {7'b0, crc_out}, 16'h155);
    check("b2b_1v", {15'b0, crc_valid}, 16'h1);
    data_in = 16'hFFFF; crc_ref = 9'h1FE; step();
    check("b2b_2", {7'b0, crc_out}, 16'h1FE);
    check("b2b_2v", {15'b0, crc_valid}, 16'h1);
    data_valid = 1'b0; data_in = 16'h1234;

    // hold and idle
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", {15'b0, crc_valid}, 16'h0);
      check("hold_out",   {7'b0, crc_out}, 16'h1FE);
    end

    // mismatch
    data_valid = 1'b1; data_in = 16'h1234; crc_ref = 9'h0ED; step();
    check("mis_out",   {7'b0, crc_out}, 16'h0EC);
    check("mis_match", {15'b0, crc_match}, 16'h0);
    check("mis_valid", {15'b0, crc_valid}, 16'h1);

    // mid-stream reset
    data_in = 16'h0001; crc_ref = 9'h133; step();
    rst = 1'b1; data_in = 16'h0002; crc_ref = 9'h155; step();
    check("mrst_out",   {7'b0, crc_out}, 16'h000);
    check("mrst_valid", {15'b0, crc_valid}, 16'h0);
    rst = 1'b0; data_in = 16'h0003; crc_ref = 9'h066; step();
    check("mrst_next", {7'b0, crc_out}, 16'h066);
    check("mrst_nextm", {15'b0, crc_match}, 16'h1);

    // random words, mostly valid, reference right about half the time
    for (int i = 0; i < 200; i++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 16'($urandom);
      crc_ref    = $urandom_range(0, 1) ? model_crc(data_in) : 9'($urandom);
      step();
    end
    data_valid = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
